bus_trace_buffer: RTL and testbench

Hardware bus-transaction recorder that sits beside `cpu_top` on the shared address/data bus. It captures every memory read/write into a parametrised circular buffer, tagging each entry with a cycle timestamp. Capture supports stop-on-full or wrap modes, an optional address trigger with post-trigger depth, and halt-stop. Captured entries are drained oldest-first through a valid/ready pop port. It replaces simulation-only `$write` bus monitoring with a synthesizable trace.

---
 rtl/bus_trace_buffer_if.sv | 30 +++
 rtl/bus_trace_buffer.sv | 155 +++++++++++++++
 tb/tb_bus_trace_buffer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_trace_buffer_if.sv
// Bus bundle for the trace buffer: the CPU address/data bus and strobes
// it observes, plus the valid/ready pop port used to drain captured entries.
interface bus_trace_buffer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TS_WIDTH   = 16
);
    localparam int ENTRY_WIDTH = TS_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH;

    logic [ADDR_WIDTH-1:0]  addr_bus;
    logic [DATA_WIDTH-1:0]  data_bus;
    logic                   mem_read;
    logic                   mem_write;
    logic                   halt;
    logic                   out_ready;
    logic                   out_valid;
    logic [ENTRY_WIDTH-1:0] out_data;

    // CPU side / trace consumer: drives the bus and pops entries
    modport master (
        output addr_bus, data_bus, mem_read, mem_write, halt, out_ready,
        input  out_valid, out_data
    );

    // Trace buffer: watches the bus and presents the oldest entry
    modport slave (
        input  addr_bus, data_bus, mem_read, mem_write, halt, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/bus_trace_buffer.sv
// Synthesizable bus-transaction recorder. Captures CPU reads/writes into a
// circular buffer with a saturating cycle stamp, supports stop-on-full or
// wrap, an address trigger with post-trigger depth and halt-stop, and
// drains oldest-first once capture is DONE.
module bus_trace_buffer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 16,
    parameter int POST_COUNT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    bus_trace_buffer_if.slave       bus,
    input  logic                    arm,
    input  logic                    mode_wrap,
    input  logic                    trig_en,
    input  logic [ADDR_WIDTH-1:0]   trig_addr,
    output logic [$clog2(DEPTH):0]  count,
    output logic [1:0]              state_out,
    output logic                    overflow,
    output logic                    triggered
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = TS_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] POST_C  = CNT_W'(POST_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      post_cnt;
    logic [TS_WIDTH-1:0]   stamp;
    logic                  wrap_q;
    logic                  trig_en_q;
    logic [ADDR_WIDTH-1:0] trig_addr_q;
    logic                  overflow_q;
    logic                  triggered_q;

    logic record;
    logic full;
    logic trig_hit;
    logic post_done;
    logic stop_full;
    logic start;
    logic pop;
    logic head_valid;

    // A recorded transaction is any strobe seen while capturing. The trigger
    // only fires once per capture; later matching addresses just count down.
    // A pop in DONE loses to a simultaneous arm, which restarts capture.
    always_comb begin
        record     = (state_q == CAPTURE) && (bus.mem_read || bus.mem_write);
        full       = (count_q == DEPTH_C);
        trig_hit   = record && trig_en_q && !triggered_q && (bus.addr_bus == trig_addr_q);
        post_done  = record && ((trig_hit && (POST_C == '0)) ||
                                (triggered_q && (post_cnt == CNT_W'(1))));
        stop_full  = record && !wrap_q && (count_q == DEPTH_C - 1'b1);
        start      = arm && (state_q != CAPTURE);
        head_valid = (state_q == DONE) && (count_q != '0);
        pop        = head_valid && bus.out_ready && !arm;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: arm starts capture from IDLE or DONE; halt, post-trigger
    // exhaustion or a full stop-mode buffer ends it on the same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arm) state_d = CAPTURE;
            CAPTURE: if (bus.halt || post_done || stop_full) state_d = DONE;
            DONE:    if (arm) state_d = CAPTURE;
            default: state_d = IDLE;
        endcase
    end

    // Pointers, occupancy, stamp, trigger bookkeeping and sticky flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            post_cnt    <= '0;
            stamp       <= '0;
            wrap_q      <= 1'b0;
            trig_en_q   <= 1'b0;
            trig_addr_q <= '0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
        end else if (start) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            post_cnt    <= '0;
            stamp       <= '0;
            wrap_q      <= mode_wrap;
            trig_en_q   <= trig_en;
            trig_addr_q <= trig_addr;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            if (state_q == CAPTURE) begin
                if (stamp != '1) stamp <= stamp + 1'b1;
                if (record) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (full) begin
                        rd_ptr     <= rd_ptr + 1'b1;
                        overflow_q <= 1'b1;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                    if (trig_hit) begin
                        triggered_q <= 1'b1;
                        post_cnt    <= POST_C;
                    end else if (triggered_q && (post_cnt != '0)) begin
                        post_cnt <= post_cnt - 1'b1;
                    end
                end
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Entry storage; contents need no reset because the output is gated
    always_ff @(posedge clk) begin
        if (record) mem[wr_ptr] <= {stamp, bus.mem_write, bus.addr_bus, bus.data_bus};
    end

    // Output view of the head entry and status
    always_comb begin
        bus.out_valid = head_valid;
        bus.out_data  = head_valid ? mem[rd_ptr] : '0;
        count         = count_q;
        state_out     = state_q;
        overflow      = overflow_q;
        triggered     = triggered_q;
    end
endmodule

// File: tb/tb_bus_trace_buffer.sv
// Testbench for bus_trace_buffer: directed scenarios plus randomized traffic,
// checked by a queue-based reference model and a negedge monitor/scoreboard.
module tb_bus_trace_buffer;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int TSW = 4;
    localparam int POST = 2;
    localparam int EW = TSW + 1 + AW + DW;
    localparam int TS_MAX = (1 << TSW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic arm = 1'b0;
    logic mode_wrap = 1'b0;
    logic trig_en = 1'b0;
    logic [AW-1:0] trig_addr = '0;
    logic [$clog2(DEPTH):0] count;
    logic [1:0] state_out;
    logic overflow;
    logic triggered;

    int checks = 0;
    int errors = 0;

    bus_trace_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TS_WIDTH(TSW)) bus ();

    bus_trace_buffer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .TS_WIDTH(TSW), .POST_COUNT(POST)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .arm(arm),
        .mode_wrap(mode_wrap), .trig_en(trig_en), .trig_addr(trig_addr),
        .count(count), .state_out(state_out), .overflow(overflow),
        .triggered(triggered)
    );

    always #5 clk = ~clk;

    // Reference model: the buffer is simply a queue of entries, oldest first
    logic [EW-1:0] exp_q[$];
    int m_state = 0;
    int m_stamp = 0;
    int m_post = 0;
    logic m_wrap = 1'b0;
    logic m_trig_en = 1'b0;
    logic [AW-1:0] m_trig_addr = '0;
    logic m_trig = 1'b0;
    logic m_ovf = 1'b0;
    logic mon_valid;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_state = 0; m_stamp = 0; m_post = 0; m_trig = 1'b0; m_ovf = 1'b0;
        m_wrap = 1'b0; m_trig_en = 1'b0; m_trig_addr = '0;
    endtask

    task automatic model_start();
        exp_q.delete();
        m_state = 1; m_stamp = 0; m_post = 0; m_trig = 1'b0; m_ovf = 1'b0;
        m_wrap = mode_wrap; m_trig_en = trig_en; m_trig_addr = trig_addr;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge
    task automatic model_step();
        logic done;
        logic [TSW-1:0] ts;
        if (!reset) begin
            model_reset();
            return;
        end
        case (m_state)
            0: if (arm) model_start();
            1: begin
                done = bus.halt;
                if (bus.mem_read || bus.mem_write) begin
                    ts = TSW'(m_stamp);
                    exp_q.push_back({ts, bus.mem_write, bus.addr_bus, bus.data_bus});
                    if (exp_q.size() > DEPTH) begin
                        void'(exp_q.pop_front());
                        m_ovf = 1'b1;
                    end
                    if (m_trig_en && !m_trig && bus.addr_bus == m_trig_addr) begin
                        m_trig = 1'b1;
                        m_post = POST;
                        if (m_post == 0) done = 1'b1;
                    end else if (m_trig) begin
                        m_post--;
                        if (m_post == 0) done = 1'b1;
                    end
                    if (!m_wrap && exp_q.size() == DEPTH) done = 1'b1;
                end
                if (m_stamp < TS_MAX) m_stamp++;
                if (done) m_state = 2;
            end
            default: if (arm) model_start();
        endcase
    endtask

    // Monitor: compare status every cycle and pop/compare the head on handshakes
    always @(negedge clk) begin
        mon_valid = (m_state == 2) && (exp_q.size() != 0);
        check_output("state_out", 32'(state_out), 32'(m_state));
        check_output("count", 32'(count), 32'(exp_q.size()));
        check_output("out_valid", 32'(bus.out_valid), 32'(mon_valid));
        check_output("overflow", 32'(overflow), 32'(m_ovf));
        check_output("triggered", 32'(triggered), 32'(m_trig));
        if (reset && mon_valid && bus.out_ready && !arm) begin
            check_output("pop_data", 32'(bus.out_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
        end
    end

    // Drive one cycle of inputs, let the edge happen, then step the model
    task automatic apply_stimulus(input logic rd, input logic wr, input logic [AW-1:0] a,
                                  input logic [DW-1:0] d, input logic h, input logic ar,
                                  input logic rdy);
        bus.mem_read = rd; bus.mem_write = wr; bus.addr_bus = a; bus.data_bus = d;
        bus.halt = h; arm = ar; bus.out_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic arm_cycle();
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    // Safety net so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        logic [EW-1:0] head;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.addr_bus = '0; bus.data_bus = '0;
        bus.halt = 1'b0; bus.out_ready = 1'b0;
        idle_cycle();
        idle_cycle();
        reset = 1'b1;
        idle_cycle();

        // Reset in the middle of a capture
        arm_cycle();
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 16'(16'h0050 + i), 8'h11, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        model_reset();
        #1;
        check_output("rst_state", 32'(state_out), 32'd0);
        check_output("rst_count", 32'(count), 32'd0);
        check_output("rst_out_data", 32'(bus.out_data), 32'd0);
        check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
        idle_cycle();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 16'(i), 8'h22, 1'b0, 1'b0, 1'b0);
        check_output("noarm_count", 32'(count), 32'd0);

        // Stop mode fills and stops after the fourth read
        mode_wrap = 1'b0; trig_en = 1'b0;
        arm_cycle();
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 1'b0, 16'(i), 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        idle_cycle();
        head = {4'd0, 1'b0, 16'h0000, 8'hA0};
        check_output("stop_state", 32'(state_out), 32'd2);
        check_output("stop_count", 32'(count), 32'd4);
        check_output("stop_overflow", 32'(overflow), 32'd0);
        check_output("stop_head", 32'(bus.out_data), 32'(head));
        drain(DEPTH + 1);

        // Wrap mode overwrites oldest, halt on last write
        mode_wrap = 1'b1;
        arm_cycle();
        for (int i = 0; i < 6; i++)
            apply_stimulus(1'b0, 1'b1, 16'(16'h0100 + i), 8'(8'h50 + i), (i == 5), 1'b0, 1'b0);
        head = {4'd2, 1'b1, 16'h0102, 8'h52};
        check_output("wrap_count", 32'(count), 32'd4);
        check_output("wrap_overflow", 32'(overflow), 32'd1);
        check_output("wrap_head", 32'(bus.out_data), 32'(head));
        drain(DEPTH + 1);

        // Address trigger with two post-trigger entries
        trig_en = 1'b1; trig_addr = 16'h0110;
        arm_cycle();
        for (int i = 0; i < 8; i++)
            apply_stimulus(1'b1, 1'b0, 16'(16'h010C + i), 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        head = {4'd3, 1'b0, 16'h010F, 8'h13};
        check_output("trig_state", 32'(state_out), 32'd2);
        check_output("trig_flag", 32'(triggered), 32'd1);
        check_output("trig_count", 32'(count), 32'd4);
        check_output("trig_head", 32'(bus.out_data), 32'(head));
        drain(DEPTH + 1);
        trig_en = 1'b0;

        // Timestamp gaps at capture cycles 0, 3 and 7
        mode_wrap = 1'b0;
        arm_cycle();
        for (int c = 0; c < 8; c++) begin
            if (c == 0 || c == 3 || c == 7)
                apply_stimulus(1'b1, 1'b0, 16'(16'h0300 + c), 8'(c), (c == 7), 1'b0, 1'b0);
            else
                idle_cycle();
        end
        head = {4'd0, 1'b0, 16'h0300, 8'h00};
        check_output("gap_count", 32'(count), 32'd3);
        check_output("gap_head", 32'(bus.out_data), 32'(head));
        drain(DEPTH);

        // Stamp saturates at all-ones
        mode_wrap = 1'b1;
        arm_cycle();
        for (int i = 0; i < 20; i++) idle_cycle();
        apply_stimulus(1'b1, 1'b0, 16'h0400, 8'h77, 1'b1, 1'b0, 1'b0);
        head = {4'hF, 1'b0, 16'h0400, 8'h77};
        check_output("sat_head", 32'(bus.out_data), 32'(head));
        drain(2);

        // Arm wins over a pop in DONE with two entries held
        arm_cycle();
        apply_stimulus(1'b1, 1'b0, 16'h0500, 8'h01, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 16'h0501, 8'h02, 1'b1, 1'b0, 1'b0);
        check_output("pre_arm_count", 32'(count), 32'd2);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        check_output("armpop_state", 32'(state_out), 32'd1);
        check_output("armpop_count", 32'(count), 32'd0);

        // Pop request with nothing held has no effect
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        drain(3);
        check_output("empty_count", 32'(count), 32'd0);
        check_output("empty_valid", 32'(bus.out_valid), 32'd0);

        // Randomized traffic across modes, triggers, halts, arms and pops
        for (int i = 0; i < 1500; i++) begin
            mode_wrap = 1'($urandom_range(0, 1));
            trig_en = 1'($urandom_range(0, 1));
            trig_addr = 16'(16'h0200 + $urandom_range(0, 5));
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           16'(16'h0200 + $urandom_range(0, 5)), 8'($urandom),
                           ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0),
                           1'($urandom_range(0, 1)));
        end
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
